bist_signature_analyzer: RTL and testbench

Response-side BIST block: compresses the responses from the circuit under test into a multiple-input signature register (MISR) and compares the final signature and response count against golden values. It sits at the far end of the BIST loop from the clock controller and LFSR pattern generator. It consumes the controller's `bist_enable`, `bist_start` and `bist_done` and reports pass/fail to the test host. It uses one clock with a synchronous reset.

---
 rtl/bist_signature_analyzer.sv | 150 +++++++++++++++
 tb/tb_bist_signature_analyzer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_signature_analyzer.sv
// Response-side BIST: compresses CUT responses into a MISR, counts them, and
// compares the final signature and count against golden values.
module bist_signature_analyzer #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   bist_enable,
  input  logic                   bist_start,
  input  logic                   bist_done,
  input  logic                   resp_valid,
  input  logic [WIDTH-1:0]       resp_data,
  input  logic [WIDTH-1:0]       golden_sig,
  input  logic [COUNT_WIDTH-1:0] golden_count,
  output logic [WIDTH-1:0]       sig_out,
  output logic [COUNT_WIDTH-1:0] resp_count,
  output logic                   busy,
  output logic                   sig_valid,
  output logic                   pass,
  output logic                   fail
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEED    = 3'd1,
    COLLECT = 3'd2,
    COMPARE = 3'd3,
    RESULT  = 3'd4
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  state_t                 state;
  logic                   fb_c;
  logic [WIDTH-1:0]       next_sig_c;
  logic [COUNT_WIDTH-1:0] next_count_c;
  logic                   match_c;

  // Feedback taps match the pattern generator's polynomial for each width.
  generate
    if (WIDTH == 16) begin : g_fb16
      assign fb_c = sig_out[15] ^ sig_out[13] ^ sig_out[12] ^ sig_out[10];
    end else if (WIDTH == 8) begin : g_fb8
      assign fb_c = sig_out[7] ^ sig_out[5] ^ sig_out[4] ^ sig_out[3];
    end else begin : g_fbn
      assign fb_c = sig_out[WIDTH-1] ^ sig_out[0];
    end
  endgenerate

  assign next_sig_c   = {sig_out[WIDTH-2:0], fb_c} ^ resp_data;
  assign next_count_c = (resp_count == COUNT_MAX) ? resp_count : resp_count + COUNT_ONE;
  assign match_c      = (sig_out == golden_sig) && (resp_count == golden_count);

  // Every path back to IDLE leaves all outputs at their reset values.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      sig_out    <= '0;
      resp_count <= '0;
      busy       <= 1'b0;
      sig_valid  <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sig_out    <= '0;
          resp_count <= '0;
          busy       <= 1'b0;
          sig_valid  <= 1'b0;
          pass       <= 1'b0;
          fail       <= 1'b0;
          if (bist_enable && bist_start) begin
            state <= SEED;
            busy  <= 1'b1;
          end
        end

        SEED: begin
          sig_out    <= '0;
          resp_count <= '0;
          if (!bist_enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= COLLECT;
          end
        end

        COLLECT: begin
          if (!bist_enable) begin
            state      <= IDLE;
            sig_out    <= '0;
            resp_count <= '0;
            busy       <= 1'b0;
          end else begin
            // A response coincident with bist_done is still absorbed.
            if (resp_valid) begin
              sig_out    <= next_sig_c;
              resp_count <= next_count_c;
            end
            if (bist_done) begin
              state <= COMPARE;
            end
          end
        end

        COMPARE: begin
          if (!bist_enable) begin
            state      <= IDLE;
            sig_out    <= '0;
            resp_count <= '0;
            busy       <= 1'b0;
          end else begin
            state     <= RESULT;
            busy      <= 1'b0;
            sig_valid <= 1'b1;
            pass      <= match_c;
            fail      <= !match_c;
          end
        end

        RESULT: begin
          if (!bist_enable || bist_start) begin
            state      <= IDLE;
            sig_out    <= '0;
            resp_count <= '0;
            busy       <= 1'b0;
            sig_valid  <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          sig_out    <= '0;
          resp_count <= '0;
          busy       <= 1'b0;
          sig_valid  <= 1'b0;
          pass       <= 1'b0;
          fail       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Directed bench for bist_signature_analyzer (WIDTH=16, COUNT_WIDTH=8).
module tb_bist_signature_analyzer;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        bist_enable;
  logic        bist_start;
  logic        bist_done;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic [15:0] golden_sig;
  logic [7:0]  golden_count;
  logic [15:0] sig_out;
  logic [7:0]  resp_count;
  logic        busy;
  logic        sig_valid;
  logic        pass;
  logic        fail;

  int total = 0;
  int bad   = 0;

  bist_signature_analyzer #(.WIDTH(16), .COUNT_WIDTH(8)) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .bist_enable  (bist_enable),
    .bist_start   (bist_start),
    .bist_done    (bist_done),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .golden_sig   (golden_sig),
    .golden_count (golden_count),
    .sig_out      (sig_out),
    .resp_count   (resp_count),
    .busy         (busy),
    .sig_valid    (sig_valid),
    .pass         (pass),
    .fail         (fail)
  );

  always #5 clk_in = ~clk_in;

  // Advance one rising edge and settle; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Start in IDLE; after return the DUT is in COLLECT.
  task automatic start_run();
    bist_enable = 1'b1;
    bist_start  = 1'b1;
    tick();
    bist_start  = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%b exp=1", busy); end
    tick();
  endtask

  task automatic send(input logic [15:0] w);
    resp_valid = 1'b1;
    resp_data  = w;
    tick();
    resp_valid = 1'b0;
    resp_data  = 16'h0000;
  endtask

  // Pulse bist_done and wait through COMPARE into RESULT.
  task automatic finish_run();
    bist_done = 1'b1;
    tick();
    bist_done = 1'b0;
    total++;
    if (busy !== 1'b1 || sig_valid !== 1'b0) begin
      bad++; $display("FAIL compare_phase busy=%b sig_valid=%b exp busy=1 sig_valid=0", busy, sig_valid);
    end
    tick();
    total++;
    if (busy !== 1'b0 || sig_valid !== 1'b1) begin
      bad++; $display("FAIL result_phase busy=%b sig_valid=%b exp busy=0 sig_valid=1", busy, sig_valid);
    end
  endtask

  task automatic go_idle();
    bist_enable = 1'b0;
    tick();
    bist_enable = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; bist_enable = 1'b0; bist_start = 1'b0; bist_done = 1'b0;
    resp_valid = 1'b0; resp_data = 16'h0; golden_sig = 16'h0; golden_count = 8'h0;
    tick();
    tick();
    total++;
    if ({sig_out, resp_count, busy, sig_valid, pass, fail} !== 28'h0) begin
      bad++; $display("FAIL reset_outputs got sig=%h cnt=%0d busy=%b sv=%b p=%b f=%b exp all 0",
                      sig_out, resp_count, busy, sig_valid, pass, fail);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_run();
    start_run();
    for (int i = 0; i < 4; i++) begin
      send(16'h0000);
      total++;
      if (sig_out !== 16'h0000) begin bad++; $display("FAIL zero_sig got=%h exp=0000", sig_out); end
    end
    total++;
    if (resp_count !== 8'd4) begin bad++; $display("FAIL zero_count got=%0d exp=4", resp_count); end
    golden_sig = 16'h0000; golden_count = 8'd4;
    finish_run();
    total++;
    if (pass !== 1'b1 || fail !== 1'b0) begin bad++; $display("FAIL zero_pass got p=%b f=%b exp p=1 f=0", pass, fail); end
    go_idle();
  endtask

  task automatic test_shift_feedback();
    start_run();
    send(16'h8000);
    total++;
    if (sig_out !== 16'h8000) begin bad++; $display("FAIL shift_a1 got=%h exp=8000", sig_out); end
    send(16'h0000);
    total++;
    if (sig_out !== 16'h0001) begin bad++; $display("FAIL shift_a2 got=%h exp=0001", sig_out); end
    go_idle();
    start_run();
    send(16'h0001);
    total++;
    if (sig_out !== 16'h0001) begin bad++; $display("FAIL shift_b1 got=%h exp=0001", sig_out); end
    send(16'h0000);
    total++;
    if (sig_out !== 16'h0002) begin bad++; $display("FAIL shift_b2 got=%h exp=0002", sig_out); end
    go_idle();
  endtask

  task automatic test_mismatch();
    start_run();
    for (int i = 0; i < 4; i++) send(16'h0000);
    golden_sig = 16'h0001; golden_count = 8'd4;
    finish_run();
    total++;
    if (pass !== 1'b0 || fail !== 1'b1) begin bad++; $display("FAIL mism_sig got p=%b f=%b exp p=0 f=1", pass, fail); end
    go_idle();
    start_run();
    for (int i = 0; i < 4; i++) send(16'h0000);
    golden_sig = 16'h0000; golden_count = 8'd5;
    finish_run();
    total++;
    if (pass !== 1'b0 || fail !== 1'b1) begin bad++; $display("FAIL mism_cnt got p=%b f=%b exp p=0 f=1", pass, fail); end
    go_idle();
  endtask

  // 0x8000 -> 8000; then {0000,fb=1} ^ 1234 = 1235 absorbed with bist_done.
  task automatic test_done_with_valid();
    start_run();
    send(16'h8000);
    resp_valid = 1'b1; resp_data = 16'h1234; bist_done = 1'b1;
    tick();
    resp_valid = 1'b0; resp_data = 16'h0; bist_done = 1'b0;
    total++;
    if (sig_out !== 16'h1235 || resp_count !== 8'd2) begin
      bad++; $display("FAIL done_valid got sig=%h cnt=%0d exp sig=1235 cnt=2", sig_out, resp_count);
    end
    golden_sig = 16'h1235; golden_count = 8'd2;
    tick();
    total++;
    if (sig_valid !== 1'b1 || pass !== 1'b1) begin
      bad++; $display("FAIL done_valid_pass got sv=%b p=%b exp sv=1 p=1", sig_valid, pass);
    end
    // Result must hold while the host idles.
    bist_done = 1'b1; resp_valid = 1'b1; resp_data = 16'hFFFF;
    tick();
    tick();
    bist_done = 1'b0; resp_valid = 1'b0; resp_data = 16'h0;
    total++;
    if (sig_valid !== 1'b1 || pass !== 1'b1 || sig_out !== 16'h1235 || resp_count !== 8'd2) begin
      bad++; $display("FAIL result_hold got sv=%b p=%b sig=%h cnt=%0d exp sv=1 p=1 sig=1235 cnt=2",
                      sig_valid, pass, sig_out, resp_count);
    end
  endtask

  // Entered from RESULT of the previous test.
  task automatic test_restart();
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
    total++;
    if (sig_valid !== 1'b0 || pass !== 1'b0 || fail !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL restart_clear got sv=%b p=%b f=%b busy=%b exp all 0", sig_valid, pass, fail, busy);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL restart_consumed got busy=%b exp=0", busy); end
    start_run();
    total++;
    if (sig_out !== 16'h0000 || resp_count !== 8'd0) begin
      bad++; $display("FAIL restart_fresh got sig=%h cnt=%0d exp sig=0000 cnt=0", sig_out, resp_count);
    end
    go_idle();
  endtask

  task automatic test_abort();
    start_run();
    send(16'h0001); send(16'h0002); send(16'h0003);
    bist_enable = 1'b0; resp_valid = 1'b1; resp_data = 16'hAAAA;
    tick();
    resp_valid = 1'b0; resp_data = 16'h0;
    total++;
    if (busy !== 1'b0 || sig_valid !== 1'b0) begin
      bad++; $display("FAIL abort got busy=%b sv=%b exp 0 0", busy, sig_valid);
    end
    bist_enable = 1'b1; bist_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (sig_valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL abort_idle got sv=%b busy=%b exp 0 0", sig_valid, busy);
      end
    end
    bist_done = 1'b0;
    total++;
    if (sig_out !== 16'h0000 || resp_count !== 8'd0) begin
      bad++; $display("FAIL abort_cleared got sig=%h cnt=%0d exp 0 0", sig_out, resp_count);
    end
  endtask

  task automatic test_reset_mid_run();
    start_run();
    send(16'h5555); send(16'h1111);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({sig_out, resp_count, busy, sig_valid, pass, fail} !== 28'h0) begin
      bad++; $display("FAIL reset_mid got sig=%h cnt=%0d busy=%b sv=%b p=%b f=%b exp all 0",
                      sig_out, resp_count, busy, sig_valid, pass, fail);
    end
    tick();
  endtask

  task automatic test_saturation();
    start_run();
    for (int i = 0; i < 255; i++) send(16'h0000);
    total++;
    if (resp_count !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d exp=255", resp_count); end
    for (int i = 0; i < 45; i++) send(16'h0000);
    total++;
    if (resp_count !== 8'd255) begin bad++; $display("FAIL sat_300 got=%0d exp=255", resp_count); end
    golden_sig = 16'h0000; golden_count = 8'd255;
    finish_run();
    total++;
    if (pass !== 1'b1 || fail !== 1'b0) begin bad++; $display("FAIL sat_pass got p=%b f=%b exp p=1 f=0", pass, fail); end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_zero_run();
    test_shift_feedback();
    test_mismatch();
    test_done_with_valid();
    test_restart();
    test_abort();
    test_reset_mid_run();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
